// File: rtl/pulse_height_detector_if.sv
// Event output channel of the pulse height detector: single-entry valid/ready register.
interface pulse_height_detector_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned WID_W  = 8
) ();
  logic                     ev_valid;
  logic                     ev_ready;
  logic signed [DATA_W-1:0] ev_amp;
  logic [TS_W-1:0]          ev_time;
  logic [WID_W-1:0]         ev_width;

  modport master (
    output ev_valid,
    output ev_amp,
    output ev_time,
    output ev_width,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_amp,
    input  ev_time,
    input  ev_width,
    output ev_ready
  );
endinterface

// File: rtl/pulse_height_detector.sv
// Threshold-crossing event extractor: peak, timestamp and width per pulse, pile-up
// rejection, hold-off dead time and a single-entry event output register.
module pulse_height_detector #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned WID_W     = 8,
  parameter int unsigned MAX_WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic signed [DATA_W-1:0] filter_data_i,
  input  logic signed [DATA_W-1:0] threshold_i,
  input  logic [7:0]               holdoff_i,
  pulse_height_detector_if.master  ev_o,
  output logic [15:0]              pileup_cnt_o,
  output logic [15:0]              lost_cnt_o
);

  typedef enum logic [1:0] {StIdle, StActive, StHoldoff} state_e;

  localparam logic [WID_W-1:0] WidthSat = '1;

  state_e                   state_q, state_d;
  logic                     armed_q, armed_d;
  logic [TS_W-1:0]          ts_q;
  logic signed [DATA_W-1:0] peak_q, peak_d;
  logic [TS_W-1:0]          t0_q, t0_d;
  logic [WID_W-1:0]         width_q, width_d;
  logic [7:0]               hcnt_q, hcnt_d;

  logic                     ev_valid_q, ev_valid_d;
  logic signed [DATA_W-1:0] ev_amp_q, ev_amp_d;
  logic [TS_W-1:0]          ev_time_q, ev_time_d;
  logic [WID_W-1:0]         ev_width_q, ev_width_d;
  logic [15:0]              pileup_q, pileup_d;
  logic [15:0]              lost_q, lost_d;

  logic above;
  logic issue;
  logic pile_inc;
  logic load;

  assign above = filter_data_i > threshold_i;

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    peak_d   = peak_q;
    t0_d     = t0_q;
    width_d  = width_q;
    hcnt_d   = hcnt_q;
    issue    = 1'b0;
    pile_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        // After hold-off a below-or-equal sample must be seen before re-triggering.
        if (!armed_q) begin
          if (!above) armed_d = 1'b1;
        end else if (above) begin
          state_d = StActive;
          peak_d  = filter_data_i;
          t0_d    = ts_q;
          width_d = WID_W'(1);
        end
      end
      StActive: begin
        if (above) begin
          if (width_q != WidthSat) width_d = width_q + WID_W'(1);
          if (filter_data_i > peak_q) peak_d = filter_data_i;
        end else begin
          state_d = StHoldoff;
          hcnt_d  = holdoff_i;
          armed_d = 1'b0;
          if (32'(width_q) > MAX_WIDTH) pile_inc = 1'b1;
          else                          issue    = 1'b1;
        end
      end
      StHoldoff: begin
        if (hcnt_q == 8'd0) state_d = StIdle;
        else                hcnt_d  = hcnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load       = issue && (!ev_valid_q || ev_o.ev_ready);
    ev_valid_d = ev_valid_q;
    ev_amp_d   = ev_amp_q;
    ev_time_d  = ev_time_q;
    ev_width_d = ev_width_q;
    pileup_d   = pileup_q;
    lost_d     = lost_q;
    if (load) begin
      ev_valid_d = 1'b1;
      ev_amp_d   = peak_q;
      ev_time_d  = t0_q;
      ev_width_d = width_q;
    end else if (ev_o.ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if (issue && !load && lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
    if (pile_inc && pileup_q != 16'hFFFF) pileup_d = pileup_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      armed_q    <= 1'b1;
      ts_q       <= '0;
      peak_q     <= '0;
      t0_q       <= '0;
      width_q    <= '0;
      hcnt_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_amp_q   <= '0;
      ev_time_q  <= '0;
      ev_width_q <= '0;
      pileup_q   <= '0;
      lost_q     <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      ts_q       <= ts_q + TS_W'(1);
      peak_q     <= peak_d;
      t0_q       <= t0_d;
      width_q    <= width_d;
      hcnt_q     <= hcnt_d;
      ev_valid_q <= ev_valid_d;
      ev_amp_q   <= ev_amp_d;
      ev_time_q  <= ev_time_d;
      ev_width_q <= ev_width_d;
      pileup_q   <= pileup_d;
      lost_q     <= lost_d;
    end
  end

  assign ev_o.ev_valid = ev_valid_q;
  assign ev_o.ev_amp   = ev_amp_q;
  assign ev_o.ev_time  = ev_time_q;
  assign ev_o.ev_width = ev_width_q;
  assign pileup_cnt_o  = pileup_q;
  assign lost_cnt_o    = lost_q;

endmodule
